// File: rtl/register_file_pkg.sv
// Shared core types for the register file: widths, index type, write-back request and a popcount helper.
`default_nettype none

package register_file_pkg;

  localparam int XLEN     = 64;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int CNT_W    = $clog2(NUM_REGS + 1);

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  xlen_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    xlen_t    data;
  } wb_req_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_if.sv
// Core-side bundle for the register file: two read ports, issue, write-back and status outputs.
`default_nettype none

interface register_file_if;
  import register_file_pkg::*;

  reg_idx_t         read_addr_a;
  reg_idx_t         read_addr_b;
  xlen_t            read_data_a;
  xlen_t            read_data_b;
  logic             read_busy_a;
  logic             read_busy_b;
  logic             issue_valid;
  reg_idx_t         issue_dest;
  logic             wb_valid;
  reg_idx_t         wb_dest;
  xlen_t            wb_data;
  logic             wb_ack;
  logic [CNT_W-1:0] busy_count;
  logic             wb_unexpected;

  modport master (
    output read_addr_a, read_addr_b, issue_valid, issue_dest, wb_valid, wb_dest, wb_data,
    input  read_data_a, read_data_b, read_busy_a, read_busy_b, wb_ack, busy_count, wb_unexpected
  );

  modport slave (
    input  read_addr_a, read_addr_b, issue_valid, issue_dest, wb_valid, wb_dest, wb_data,
    output read_data_a, read_data_b, read_busy_a, read_busy_b, wb_ack, busy_count, wb_unexpected
  );

endinterface

`default_nettype wire

// File: rtl/register_file_scoreboard.sv
// reg_scoreboard: pending bit per architectural register plus registered population count.
`default_nettype none

module reg_scoreboard
  import register_file_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                set_valid,
  input  wire reg_idx_t            set_idx,
  input  wire logic                clr_valid,
  input  wire reg_idx_t            clr_idx,
  output logic [NUM_REGS-1:0]      pending,
  output logic [CNT_W-1:0]         busy_count
);

  logic [NUM_REGS-1:0] pending_nxt;

  // Clear first so a same-cycle set on the same index wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_valid && (clr_idx != '0)) pending_nxt[clr_idx] = 1'b0;
    if (set_valid && (set_idx != '0)) pending_nxt[set_idx] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      busy_count <= '0;
    end else begin
      pending    <= pending_nxt;
      busy_count <= popcount(pending_nxt);
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// register_file: 2-read/1-write architectural register file with issue scoreboard.
// Optional same-cycle write-back bypass on the read ports: define REGFILE_BYPASS_EN.
`default_nettype none

module register_file
  import register_file_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     reset,
  register_file_if.slave bus
);

  xlen_t               regs [NUM_REGS];
  wb_req_t             wb;
  logic [NUM_REGS-1:0] pending;
  logic                wb_write;

  assign wb       = {bus.wb_valid, bus.wb_dest, bus.wb_data};
  assign wb_write = wb.valid && (wb.dest != '0);

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_valid  (bus.issue_valid),
    .set_idx    (bus.issue_dest),
    .clr_valid  (wb.valid),
    .clr_idx    (wb.dest),
    .pending    (pending),
    .busy_count (bus.busy_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.wb_ack        <= 1'b0;
      bus.wb_unexpected <= 1'b0;
    end else begin
      if (wb_write) regs[wb.dest] <= wb.data;
      bus.wb_ack <= wb.valid;
      if (wb_write && !pending[wb.dest]) bus.wb_unexpected <= 1'b1;
    end
  end

  always_comb begin
    bus.read_data_a = (bus.read_addr_a == '0) ? '0 : regs[bus.read_addr_a];
    bus.read_busy_a = pending[bus.read_addr_a];
`ifdef REGFILE_BYPASS_EN
    if (wb_write && (wb.dest == bus.read_addr_a)) begin
      bus.read_data_a = wb.data;
      bus.read_busy_a = bus.issue_valid && (bus.issue_dest == bus.read_addr_a);
    end
`endif
  end

  always_comb begin
    bus.read_data_b = (bus.read_addr_b == '0) ? '0 : regs[bus.read_addr_b];
    bus.read_busy_b = pending[bus.read_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wb_write && (wb.dest == bus.read_addr_b)) begin
      bus.read_data_b = wb.data;
      bus.read_busy_b = bus.issue_valid && (bus.issue_dest == bus.read_addr_b);
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based reference model.
`default_nettype none

module tb_register_file;
  import register_file_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  register_file_if bus();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] m_regs [32];
  bit          m_pend [32];
  bit          m_unexp;
  bit          m_ack;

  logic [63:0] last_rda;
  logic        last_busy_a;
  logic [5:0]  last_cnt;
  logic        last_ack;
  logic        last_unexp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [63:0] exp_data(input int a);
    if (a == 0) return 64'd0;
    if (BYP && bus.wb_valid && bus.wb_dest != 0 && int'(bus.wb_dest) == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    if (BYP && bus.wb_valid && bus.wb_dest != 0 && int'(bus.wb_dest) == a)
      return bus.issue_valid && int'(bus.issue_dest) == a;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 64'd0;
      m_pend[i] = 1'b0;
    end
    m_unexp = 1'b0;
    m_ack   = 1'b0;
  endtask

  // Drive one cycle of stimulus, compare at the falling edge, then advance the model at the rising edge.
  task automatic step(input int ra, input int rb, input bit iv, input int id,
                      input bit wv, input int wd, input logic [63:0] wdata);
    bus.read_addr_a = reg_idx_t'(ra);
    bus.read_addr_b = reg_idx_t'(rb);
    bus.issue_valid = iv;
    bus.issue_dest  = reg_idx_t'(id);
    bus.wb_valid    = wv;
    bus.wb_dest     = reg_idx_t'(wd);
    bus.wb_data     = wdata;
    @(negedge clk);
    check("rd_a", bus.read_data_a, exp_data(ra));
    check("rd_b", bus.read_data_b, exp_data(rb));
    check("busy_a", 64'(bus.read_busy_a), 64'(exp_busy(ra)));
    check("busy_b", 64'(bus.read_busy_b), 64'(exp_busy(rb)));
    check("busy_count", 64'(bus.busy_count), 64'(m_count()));
    check("wb_ack", 64'(bus.wb_ack), 64'(m_ack));
    check("wb_unexpected", 64'(bus.wb_unexpected), 64'(m_unexp));
    last_rda    = bus.read_data_a;
    last_busy_a = bus.read_busy_a;
    last_cnt    = bus.busy_count;
    last_ack    = bus.wb_ack;
    last_unexp  = bus.wb_unexpected;
    @(posedge clk);
    m_ack = wv;
    if (wv && wd != 0) begin
      if (!m_pend[wd]) m_unexp = 1'b1;
      m_regs[wd] = wdata;
      m_pend[wd] = 1'b0;
    end
    if (iv && id != 0) m_pend[id] = 1'b1;
    #1;
  endtask

  task automatic idle(input int ra);
    step(ra, 0, 1'b0, 0, 1'b0, 0, 64'd0);
  endtask

  function automatic int rnd_idx();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [5:0] cnt_before;
    model_reset();
    bus.read_addr_a = 5'd5;
    bus.read_addr_b = 5'd0;
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_dest     = '0;
    bus.wb_data     = '0;
    #2;
    check("rst_cnt", 64'(bus.busy_count), 64'd0);
    check("rst_ack", 64'(bus.wb_ack), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset release: x5 and x0 read zero and idle.
    step(5, 0, 1'b0, 0, 1'b0, 0, 64'd0);
    check("x5_zero", last_rda, 64'd0);
    check("x5_busy", 64'(last_busy_a), 64'd0);

    // Issue then write back x7.
    step(7, 0, 1'b1, 7, 1'b0, 0, 64'd0);
    step(7, 0, 1'b0, 0, 1'b1, 7, 64'hDEAD_BEEF);
    check("x7_busy_mid", 64'(last_busy_a), BYP ? 64'd0 : 64'd1);
    check("x7_cnt_mid", 64'(last_cnt), 64'd1);
    idle(7);
    check("x7_data", last_rda, 64'hDEAD_BEEF);
    check("x7_busy_end", 64'(last_busy_a), 64'd0);
    check("x7_cnt_end", 64'(last_cnt), 64'd0);
    check("x7_ack", 64'(last_ack), 64'd1);
    idle(7);
    check("x7_ack_once", 64'(last_ack), 64'd0);

    // x0 is never written nor pending, but the write-back is still acknowledged.
    step(0, 0, 1'b1, 0, 1'b1, 0, 64'h1234);
    idle(0);
    check("x0_data", last_rda, 64'd0);
    check("x0_cnt", 64'(last_cnt), 64'd0);
    check("x0_ack", 64'(last_ack), 64'd1);
    check("x0_unexp", 64'(last_unexp), 64'd0);

    // Same-cycle issue and write-back on a pending x3: data lands, pending stays.
    step(3, 0, 1'b1, 3, 1'b0, 0, 64'd0);
    idle(3);
    cnt_before = last_cnt;
    step(3, 0, 1'b1, 3, 1'b1, 3, 64'h55);
    idle(3);
    check("x3_data", last_rda, 64'h55);
    check("x3_busy", 64'(last_busy_a), 64'd1);
    check("x3_cnt", 64'(last_cnt), 64'(cnt_before));

    // Unexpected write-back to a non-pending x9 sets the sticky flag.
    step(9, 0, 1'b0, 0, 1'b1, 9, 64'h77);
    idle(9);
    check("x9_data", last_rda, 64'h77);
    check("x9_unexp", 64'(last_unexp), 64'd1);
    repeat (3) idle(0);
    check("x9_sticky", 64'(last_unexp), 64'd1);

    // Read during a same-cycle write-back to pending x4.
    step(0, 0, 1'b0, 0, 1'b1, 4, 64'h11);
    step(0, 0, 1'b1, 4, 1'b0, 0, 64'd0);
    step(4, 0, 1'b0, 0, 1'b1, 4, 64'hABCD);
    check("byp_data", last_rda, BYP ? 64'hABCD : 64'h11);
    check("byp_busy", 64'(last_busy_a), BYP ? 64'd0 : 64'd1);

    for (int n = 0; n < 400; n++) begin
      step(rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)), rnd_idx(),
           1'($urandom_range(0, 1)), rnd_idx(), {$urandom, $urandom});
    end

    // Asynchronous reset with traffic present; the coincident edge must be discarded.
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd6;
    bus.wb_valid    = 1'b1;
    bus.wb_dest     = 5'd6;
    bus.wb_data     = 64'hFFFF;
    bus.read_addr_a = 5'd6;
    bus.read_addr_b = 5'd3;
    #2;
    reset = 1'b0;
    #1;
    check("arst_cnt", 64'(bus.busy_count), 64'd0);
    check("arst_unexp", 64'(bus.wb_unexpected), 64'd0);
    check("arst_ack", 64'(bus.wb_ack), 64'd0);
    check("arst_x3", bus.read_data_b, 64'd0);
    @(posedge clk);
    #1;
    bus.wb_valid    = 1'b0;
    bus.issue_valid = 1'b0;
    #1;
    check("arst_x6", bus.read_data_a, 64'd0);
    check("arst_busy6", 64'(bus.read_busy_a), 64'd0);
    check("arst_ack2", 64'(bus.wb_ack), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    idle(6);
    check("post_rst_x6", last_rda, 64'd0);

    for (int n = 0; n < 100; n++) begin
      step(rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)), rnd_idx(),
           1'($urandom_range(0, 1)), rnd_idx(), {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter XLEN, 64, data width of each architectural register.
REQ-002 Parameter NUM_REGS, 32, number of architectural registers; index width is $clog2(NUM_REGS) (5 bits at default).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 read_addr_a  in  5  source register index, port A.
REQ-006 read_addr_b  in  5  source register index, port B.
REQ-007 read_data_a  out  XLEN  value of register read_addr_a.
REQ-008 read_data_b  out  XLEN  value of register read_addr_b.
REQ-009 read_busy_a  out  1  scoreboard pending bit of read_addr_a.
REQ-010 read_busy_b  out  1  scoreboard pending bit of read_addr_b.
REQ-011 issue_valid  in  1  decode issues an instruction that writes issue_dest.
REQ-012 issue_dest  in  5  destination index of the issued instruction.
REQ-013 wb_valid  in  1  write-back stage presents a completed result (write_back_done).
REQ-014 wb_dest  in  5  destination index from write-back (dest_reg_out).
REQ-015 wb_data  in  XLEN  result from write-back (data_out).
REQ-016 wb_ack  out  1  registered acknowledge, high one cycle after each accepted write.
REQ-017 busy_count  out  6  number of registers currently pending.
REQ-018 wb_unexpected  out  1  sticky flag: write-back hit a non-pending register.

Function
REQ-019 Register 0 SHALL read as zero, SHALL never be written, and SHALL never be marked pending.
REQ-020 Reads SHALL be combinational from the register array and scoreboard.
REQ-021 When wb_valid is high and wb_dest is nonzero, regs[wb_dest] SHALL take wb_data at the next edge.
REQ-022 Every write-back with wb_valid high SHALL be accepted (no back-pressure); wb_ack SHALL be high exactly the following cycle, including for wb_dest 0.
REQ-023 issue_valid with issue_dest nonzero SHALL set pending[issue_dest] at the next edge.
REQ-024 wb_valid with nonzero wb_dest SHALL clear pending[wb_dest] at the next edge.
REQ-025 Simultaneous issue and write-back to the same nonzero index SHALL write the data and leave the pending bit set (set wins).
REQ-026 Write-back to a nonzero register whose pending bit is clear SHALL still write data and SHALL set wb_unexpected until reset.
REQ-027 busy_count SHALL equal the population count of the pending bits after each edge; range 0..31, no wrap.
REQ-028 Write-back SHALL be visible on read ports no later than the cycle after wb_valid.

Reset
REQ-029 While reset is low: all registers zero, all pending bits clear, wb_ack 0, busy_count 0, wb_unexpected 0, asynchronously.
REQ-030 A write-back or issue coincident with reset assertion SHALL be discarded.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN: when defined, a read matching a same-cycle valid nonzero wb_dest SHALL return wb_data and report busy 0 (unless simultaneously re-issued); when undefined, reads return the array value and scoreboard bit, and bypass logic SHALL be absent.

Structure
REQ-032 XLEN, NUM_REGS, the register index typedef and the write-back request struct (valid, dest, data) SHALL live in the shared core package.
REQ-033 The pending-bit scoreboard and its population count SHALL be a sub-module named reg_scoreboard; the data array stays in register_file.

Verification
REQ-034 Reset release, read x5 and x0 -> read_data 0, busy 0, busy_count 0, wb_ack 0.
REQ-035 Issue x7, next cycle wb x7=0xDEAD_BEEF -> read_busy x7 1 then 0, busy_count 1 then 0, wb_ack pulses once, x7 reads 0xDEAD_BEEF.
REQ-036 Issue x0, wb x0=0x1234 -> x0 reads 0, busy_count stays 0, wb_ack 1, wb_unexpected 0.
REQ-037 Issue x3 and wb x3=0x55 same cycle (x3 pending from earlier) -> x3 reads 0x55, pending stays 1, busy_count unchanged.
REQ-038 wb x9=0x77 with x9 not pending -> x9 reads 0x77, wb_unexpected 1 and sticky until reset.
REQ-039 With REGFILE_BYPASS_EN: read x4 while wb x4=0xABCD same cycle -> read_data 0xABCD, busy 0; without it -> old value, busy 1.
